// File: rtl/i2c_master_seq.sv
// rtl/i2c_master_seq.sv - byte-level I2C master sequencer driving open-drain SCL/SDA
module i2c_master_seq #(
    parameter int DIV_STD  = 250,
    parameter int DIV_FAST = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic       cmd_read,
    input  logic       cmd_nack,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       ack_err,
    output logic       rsp_valid,
    output logic       busy,
    output logic       scl_o,
    output logic       sda_oe,
    input  logic       scl_i,
    input  logic       sda_i
);

    localparam int DIV_MAX = (DIV_STD > DIV_FAST) ? DIV_STD : DIV_FAST;
    localparam int CW      = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP,
        S_HOLD
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [1:0]      r_q, w_q_nxt;
    logic [2:0]      r_bit, w_bit_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_div_m1;
    logic            r_fast, r_read, r_nack, r_stop;
    logic            r_samp, r_busy, r_rsp, r_ack_err;
    logic [7:0]      r_shift, r_rd_data;
    logic            w_accept, w_run, w_stretch, w_tick, w_done;

    assign w_div_m1  = r_fast ? CW'(DIV_FAST - 1) : CW'(DIV_STD - 1);
    assign cmd_ready = (r_state == S_IDLE) || (r_state == S_HOLD);
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_run     = !cmd_ready;
    // A slave holding SCL low while we have released it freezes the quarter.
    assign w_stretch = !scl_i && ((((r_state == S_BIT) || (r_state == S_ACK)) && (r_q == 2'd2))
                                  || ((r_state == S_STOP) && (r_q == 2'd1)));
    assign w_tick    = w_run && !w_stretch && (r_cnt == w_div_m1);

    assign rd_data   = r_rd_data;
    assign ack_err   = r_ack_err;
    assign rsp_valid = r_rsp;
    assign busy      = r_busy;

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_bit_nxt   = r_bit;
        w_done      = 1'b0;
        scl_o       = 1'b1;
        sda_oe      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_START;
                    w_q_nxt     = 2'd0;
                    w_bit_nxt   = 3'd7;
                end
            end
            S_HOLD: begin
                scl_o = 1'b0;
                if (w_accept) begin
                    w_state_nxt = cmd_start ? S_START : S_BIT;
                    w_q_nxt     = 2'd0;
                    w_bit_nxt   = 3'd7;
                end
            end
            S_START: begin
                scl_o  = (r_q == 2'd1) || (r_q == 2'd2);
                sda_oe = r_q[1];
                if (w_tick) begin
                    w_q_nxt = r_q + 2'd1;
                    if (r_q == 2'd3) begin
                        w_state_nxt = S_BIT;
                        w_bit_nxt   = 3'd7;
                    end
                end
            end
            S_BIT: begin
                scl_o  = (r_q != 2'd0);
                sda_oe = !r_read && !r_shift[7];
                if (w_tick) begin
                    w_q_nxt = r_q + 2'd1;
                    if (r_q == 2'd3) begin
                        if (r_bit == 3'd0) begin
                            w_state_nxt = S_ACK;
                        end else begin
                            w_bit_nxt = r_bit - 3'd1;
                        end
                    end
                end
            end
            S_ACK: begin
                scl_o  = (r_q != 2'd0);
                sda_oe = r_read && !r_nack;
                if (w_tick) begin
                    w_q_nxt = r_q + 2'd1;
                    if (r_q == 2'd3) begin
                        if (r_stop) begin
                            w_state_nxt = S_STOP;
                        end else begin
                            w_state_nxt = S_HOLD;
                            w_done      = 1'b1;
                        end
                    end
                end
            end
            S_STOP: begin
                scl_o  = (r_q != 2'd0);
                sda_oe = (r_q != 2'd2);
                if (w_tick) begin
                    if (r_q == 2'd2) begin
                        w_state_nxt = S_IDLE;
                        w_q_nxt     = 2'd0;
                        w_done      = 1'b1;
                    end else begin
                        w_q_nxt = r_q + 2'd1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_q       <= 2'd0;
            r_bit     <= 3'd0;
            r_cnt     <= '0;
            r_fast    <= 1'b0;
            r_read    <= 1'b0;
            r_nack    <= 1'b0;
            r_stop    <= 1'b0;
            r_samp    <= 1'b0;
            r_busy    <= 1'b0;
            r_rsp     <= 1'b0;
            r_ack_err <= 1'b0;
            r_shift   <= 8'd0;
            r_rd_data <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_bit   <= w_bit_nxt;
            r_rsp   <= w_done;
            if (!w_run || w_stretch || w_tick) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_accept) begin
                r_fast  <= (mode == 2'd1);
                r_read  <= cmd_read;
                r_nack  <= cmd_nack;
                r_stop  <= cmd_stop;
                r_shift <= wr_data;
            end
            if (w_tick && ((r_state == S_BIT) || (r_state == S_ACK)) && (r_q == 2'd2)) begin
                r_samp <= sda_i;
            end
            // Write bits leave from the MSB while the sampled bus bit enters at the LSB.
            if (w_tick && (r_state == S_BIT) && (r_q == 2'd3)) begin
                r_shift <= {r_shift[6:0], r_samp};
            end
            if (w_tick && (r_state == S_START) && (r_q == 2'd1)) begin
                r_busy <= 1'b1;
            end
            if (w_done) begin
                r_rd_data <= r_shift;
                r_ack_err <= !r_read && r_samp;
                if (r_state == S_STOP) begin
                    r_busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_seq.sv
// tb/tb_i2c_master_seq.sv - directed self-checking bench for i2c_master_seq
module tb_i2c_master_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode = 2'd0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_start = 1'b0;
    logic       cmd_stop = 1'b0;
    logic       cmd_read = 1'b0;
    logic       cmd_nack = 1'b0;
    logic [7:0] wr_data = 8'd0;
    logic [7:0] rd_data;
    logic       ack_err;
    logic       rsp_valid;
    logic       busy;
    logic       scl_o;
    logic       sda_oe;
    logic       scl_i;
    logic       sda_i;

    logic       stretch = 1'b0;
    logic       slave_sda = 1'b1;
    logic [8:0] s_pat = 9'h1FF;
    int         s_base = 1000;
    logic       sl_in;
    logic [3:0] sl_idx;

    int         cyc = 0;
    int         rise_cnt = 0;
    int         rise_time [256];
    logic       rise_sda [256];
    int         start_cnt = 0;
    int         stop_cnt = 0;
    int         rsp_cnt = 0;
    int         busy_drops = 0;
    logic       watch_busy = 1'b0;
    logic       p_scl_o = 1'b1;
    logic       p_scl = 1'b1;
    logic       p_sda = 1'b1;
    logic       str_arm = 1'b0;
    int         str_rise = 0;
    int         str_cd = 0;
    int         str_hold = 0;

    int         n_tests = 0;
    int         n_fail = 0;

    assign scl_i  = scl_o & ~stretch;
    assign sda_i  = ~sda_oe & slave_sda;
    assign sl_in  = (rise_cnt >= s_base) && (rise_cnt <= s_base + 8);
    assign sl_idx = 4'(rise_cnt - s_base);

    i2c_master_seq #(.DIV_STD(250), .DIV_FAST(63)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop),
        .cmd_read(cmd_read), .cmd_nack(cmd_nack),
        .wr_data(wr_data), .rd_data(rd_data), .ack_err(ack_err),
        .rsp_valid(rsp_valid), .busy(busy),
        .scl_o(scl_o), .sda_oe(sda_oe), .scl_i(scl_i), .sda_i(sda_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor plus a slave that changes SDA only while SCL is low.
    always @(negedge clk) begin
        p_scl_o <= scl_o;
        p_scl   <= scl_i;
        p_sda   <= sda_i;
        if (scl_o && !p_scl_o) begin
            rise_time[8'(rise_cnt)] <= cyc;
            rise_sda[8'(rise_cnt)]  <= ~sda_oe;
            rise_cnt <= rise_cnt + 1;
            if (str_arm && rise_cnt == str_rise) str_cd <= 63;
        end
        if (p_scl && scl_i && p_sda && !sda_i) start_cnt <= start_cnt + 1;
        if (p_scl && scl_i && !p_sda && sda_i) stop_cnt <= stop_cnt + 1;
        if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
        if (watch_busy && !busy && !rsp_valid) busy_drops <= busy_drops + 1;
        if (!scl_o) slave_sda <= sl_in ? s_pat[4'd8 - sl_idx] : 1'b1;
        if (str_cd > 0) begin
            str_cd <= str_cd - 1;
            if (str_cd == 1) begin
                stretch  <= 1'b1;
                str_hold <= 500;
            end
        end
        if (str_hold > 0) begin
            str_hold <= str_hold - 1;
            if (str_hold == 1) stretch <= 1'b0;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic st, input logic sp, input logic rd, input logic nk,
                        input logic [7:0] d, input logic [1:0] md, input logic from_idle);
        @(negedge clk);
        s_base    = rise_cnt + ((st || from_idle) ? 1 : 0);
        cmd_start = st;
        cmd_stop  = sp;
        cmd_read  = rd;
        cmd_nack  = nk;
        wr_data   = d;
        mode      = md;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("ready_drop", int'(cmd_ready), 0);
    endtask

    task automatic wait_rsp(input int limit, input string tag);
        int k = 0;
        while (!rsp_valid && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(tag, int'(rsp_valid), 1);
    endtask

    task automatic wait_rise(input int idx, input int limit, input string tag);
        int k = 0;
        while (rise_cnt <= idx && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(tag, int'(rise_cnt > idx), 1);
    endtask

    function automatic int period(input int idx);
        return rise_time[8'(idx + 1)] - rise_time[8'(idx)];
    endfunction

    initial begin
        int rc0, st0, sp0, b0;
        logic [7:0] b;

        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_scl", int'(scl_o), 1);
        check("rst_sda_oe", int'(sda_oe), 0);
        check("rst_ready", int'(cmd_ready), 1);
        check("rst_rsp", int'(rsp_valid), 0);
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_ack_err", int'(ack_err), 0);
        check("rst_busy", int'(busy), 0);

        // Standard-mode write 0xA4 with START and STOP, slave ACKs.
        s_pat = {8'hFF, 1'b0};
        rc0 = rsp_cnt; st0 = start_cnt; sp0 = stop_cnt;
        send(1'b1, 1'b1, 1'b0, 1'b0, 8'hA4, 2'd0, 1'b1);
        b0 = s_base;
        wait_rise(b0, 3000, "t1_first_rise");
        check("t1_busy_mid", int'(busy), 1);
        wait_rsp(15000, "t1_rsp");
        repeat (3) @(negedge clk);
        b = 8'd0;
        for (int i = 0; i < 8; i++) b = {b[6:0], rise_sda[8'(b0 + i)]};
        check("t1_sda_bits", int'(b), 'hA4);
        check("t1_scl_period", period(b0), 1000);
        check("t1_ack_err", int'(ack_err), 0);
        check("t1_rsp_once", rsp_cnt - rc0, 1);
        check("t1_start", start_cnt - st0, 1);
        check("t1_stop", stop_cnt - sp0, 1);
        check("t1_busy_end", int'(busy), 0);
        check("t1_ready_end", int'(cmd_ready), 1);

        // Fast-mode write 0x3C without STOP, slave NACKs: bus parks in HOLD.
        s_pat = 9'h1FF;
        rc0 = rsp_cnt; sp0 = stop_cnt;
        send(1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 2'd1, 1'b1);
        b0 = s_base;
        wait_rsp(5000, "t3_rsp");
        repeat (2) @(negedge clk);
        b = 8'd0;
        for (int i = 0; i < 8; i++) b = {b[6:0], rise_sda[8'(b0 + i)]};
        check("t3_sda_bits", int'(b), 'h3C);
        check("t3_ack_err", int'(ack_err), 1);
        check("t3_busy", int'(busy), 1);
        check("t3_scl_low", int'(scl_o), 0);
        check("t3_ready", int'(cmd_ready), 1);
        check("t3_rsp_once", rsp_cnt - rc0, 1);
        check("t3_no_stop", stop_cnt - sp0, 0);

        // Fast read from HOLD without START, master NACKs, slave returns 0x5B.
        s_pat = {8'h5B, 1'b1};
        st0 = start_cnt;
        send(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 2'd1, 1'b0);
        b0 = s_base;
        wait_rsp(5000, "t2_rsp");
        repeat (2) @(negedge clk);
        check("t2_rd_data", int'(rd_data), 'h5B);
        check("t2_ack_err", int'(ack_err), 0);
        check("t2_nack_released", int'(rise_sda[8'(b0 + 8)]), 1);
        check("t2_scl_period", period(b0), 252);
        check("t2_no_start", start_cnt - st0, 0);
        check("t2_busy", int'(busy), 1);

        // Repeated START from HOLD, mode 3 falls back to standard timing, then STOP.
        s_pat = {8'hFF, 1'b0};
        st0 = start_cnt; sp0 = stop_cnt;
        watch_busy = 1'b1;
        send(1'b1, 1'b1, 1'b0, 1'b0, 8'h81, 2'd3, 1'b0);
        b0 = s_base;
        wait_rsp(15000, "t4_rsp");
        watch_busy = 1'b0;
        repeat (2) @(negedge clk);
        check("t4_sda_rel_at_rise", int'(rise_sda[8'(b0 - 1)]), 1);
        check("t4_rstart", start_cnt - st0, 1);
        check("t4_stop", stop_cnt - sp0, 1);
        check("t4_busy_held", busy_drops, 0);
        check("t4_scl_period", period(b0), 1000);
        check("t4_ack_err", int'(ack_err), 0);
        check("t4_busy_end", int'(busy), 0);

        // Fast read with a 500-clock stretch at the start of bit 3 Q2.
        s_pat = {8'hC3, 1'b1};
        send(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 2'd1, 1'b1);
        b0 = s_base;
        str_rise = b0 + 3;
        str_arm = 1'b1;
        wait_rsp(8000, "t5_rsp");
        str_arm = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_rd_data", int'(rd_data), 'hC3);
        check("t5_pre_stretch", period(b0 + 2), 252);
        check("t5_stretched", period(b0 + 3), 752);
        check("t5_post_stretch", period(b0 + 4), 252);
        check("t5_ack_driven", int'(rise_sda[8'(b0 + 8)]), 0);
        check("t5_busy_end", int'(busy), 0);

        // Reset in the middle of bit 5 releases the bus with no response.
        s_pat = {8'hFF, 1'b0};
        send(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 2'd1, 1'b1);
        b0 = s_base;
        wait_rise(b0 + 5, 5000, "t6_bit5_rise");
        repeat (20) @(negedge clk);
        check("t6_busy_before", int'(busy), 1);
        rc0 = rsp_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("t6_scl", int'(scl_o), 1);
        check("t6_sda_oe", int'(sda_oe), 0);
        check("t6_busy", int'(busy), 0);
        check("t6_ready", int'(cmd_ready), 1);
        check("t6_rsp", int'(rsp_valid), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_no_rsp", rsp_cnt - rc0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_master_seq.md
Name: i2c_master_seq

Overview:
- Byte-level I2C master sequencer: accepts one-byte commands (optional START/repeated START, write or read byte, ACK/NACK, optional STOP) and drives the open-drain SCL/SDA pins.
- Runs off the 100 MHz system clock with an internal quarter-bit tick, standard (100 kHz) or fast (400 kHz) per command; supports slave clock stretching.
- Sits between the bus-register front end and the pad open-drain buffers.

Parameters:
- DIV_STD, 250, system clocks per quarter bit in standard mode (2.5 us).
- DIV_FAST, 63, system clocks per quarter bit in fast mode.

Ports:
- clk  in  1  100 MHz system clock
- rst  in  1  synchronous active-high reset
- mode  in  2  0 = standard, 1 = fast, others = standard; sampled at command accept
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_start  in  1  issue START (repeated START if bus held) before byte
- cmd_stop  in  1  issue STOP after ACK bit
- cmd_read  in  1  1 = read byte, 0 = write byte
- cmd_nack  in  1  read only: master sends NACK (1) / ACK (0)
- wr_data  in  8  byte to write, MSB first
- rd_data  out  8  byte read, valid with rsp_valid
- ack_err  out  1  write: slave NACKed; valid with rsp_valid
- rsp_valid  out  1  one-cycle pulse at command completion
- busy  out  1  bus owned (START issued, no STOP yet)
- scl_o  out  1  0 = pull SCL low, 1 = release
- sda_oe  out  1  1 = pull SDA low, 0 = release
- scl_i, sda_i  in  1 each  pad readback

Behaviour:
- Reset: scl_o=1, sda_oe=0, cmd_ready=1, rsp_valid=0, rd_data=0, ack_err=0, busy=0, FSM=IDLE, tick counter=0. Reset mid-transfer releases both lines on the next edge; no STOP is generated.
- Tick: counter 0..DIV-1 (DIV from latched mode); tick when counter==DIV-1, then wraps to 0. Counter runs only outside IDLE/HOLD and is held at 0 while stretched.
- States: IDLE (bus free), START, BIT, ACK, STOP, HOLD (bus owned, SCL low). Each state step is one tick.
- cmd_ready=1 only in IDLE and HOLD. On accept: latch all cmd fields and mode. cmd_ready drops the cycle after accept.
- From IDLE: START is always issued, even if cmd_start=0.
- From HOLD: START is issued only if cmd_start=1; otherwise go directly to BIT.
- START, 4 ticks: Q0 release SDA, SCL low; Q1 release SCL; Q2 pull SDA low, SCL high; Q3 pull SCL low. busy=1 from Q2.
- BIT x8, then ACK, 4 ticks each:
  - Q0: SCL low; drive SDA (write: data bit; read: release; ACK phase: write releases, read drives cmd_nack ? release : low).
  - Q1: release SCL.
  - Q2: if scl_i==0, stretch (hold counter); once high, sample sda_i. Read bits shift into a shift register. ACK sample on write → ack_err.
  - Q3: SCL high hold; at end pull SCL low.
- After ACK: go to STOP if cmd_stop, else HOLD with rsp_valid pulse.
- STOP, 3 ticks: Q0 SCL low, SDA low; Q1 release SCL (stretch honoured); Q2 release SDA. Then busy=0, rsp_valid pulse, return to IDLE.
- rd_data and ack_err update in the same cycle rsp_valid rises and hold until the next completion. For reads, ack_err=0.
- NACK on write does not abort: STOP happens only if cmd_stop. Firmware decides recovery.
- mode change while busy has no effect until the next accept.
- Byte time, standard, no stretch, no START/STOP: 36 ticks = 9000 clk.

Test Plan:
- Write 0xA4, start=1, stop=1, mode=0, sda_i ACK low → SDA sequence 1,0,1,0,0,1,0,0; START edge; STOP; ack_err=0; rsp_valid once; SCL period 1000 clk.
- Read, start=0 from HOLD, cmd_nack=1, slave drives 0x5B, mode=1 → rd_data=0x5B; SDA released at ACK bit; SCL period 252 clk.
- Write with sda_i high at ACK, stop=0 → ack_err=1, FSM in HOLD, busy=1, SCL low, cmd_ready=1.
- Repeated START: from HOLD, cmd_start=1 → SDA released before SCL rises, then SDA falls while SCL high; busy stays 1 throughout.
- Clock stretch: hold scl_i low 500 clk in bit 3 Q2 → sample is delayed exactly 500 clk and the rest of the timing is unchanged.
- rst asserted mid bit 5 → next cycle scl_o=1, sda_oe=0, busy=0, cmd_ready=1, no rsp_valid.
